// File: rtl/ibex_trace_pkg.sv
// Shared types for the retirement-trace buffer: the compact per-instruction
// record and its width.
package ibex_trace_pkg;

    // One retired instruction, most significant field first.
    typedef struct packed {
        logic [31:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic        trap;
        logic        intr;
        logic        gap;
    } trace_rec_t;

    localparam int unsigned TraceRecW = $bits(trace_rec_t);

endpackage

// File: rtl/ibex_trace_fifo.sv
// Retirement-trace FIFO. Captures one record per retired instruction and
// streams it to a valid/ready sink. The core is never back-pressured: when
// the buffer is full the record is dropped and counted. The next stored
// record carries a gap flag so the sink can see the loss.
module ibex_trace_fifo
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth    = 8,
    parameter int unsigned DropCntW = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                rvfi_valid,
    input  logic [63:0]         rvfi_order,
    input  logic [31:0]         rvfi_insn,
    input  logic                rvfi_trap,
    input  logic                rvfi_intr,
    input  logic [31:0]         rvfi_pc_rdata,
    input  logic [4:0]          rvfi_rd_addr,
    input  logic [31:0]         rvfi_rd_wdata,
    input  logic [31:0]         rvfi_mem_addr,
    input  logic [3:0]          rvfi_mem_rmask,
    input  logic [3:0]          rvfi_mem_wmask,

    input  logic                flush_i,
    input  logic                clear_drop_i,

    output logic                trace_valid_o,
    input  logic                trace_ready_i,
    output trace_rec_t          trace_rec_o,
    output logic [$clog2(Depth):0] level_o,
    output logic [DropCntW-1:0] drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    // Only the low half of the retirement index is kept in the record.
    logic unused_order_hi;
    assign unused_order_hi = ^rvfi_order[63:32];

    trace_rec_t          mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                gap_q, gap_d;
    logic [DropCntW-1:0] drop_q, drop_d;
    logic                rd_seen_q;

    logic                full;
    logic                not_empty;
    logic                pop;
    logic                store;
    logic                drop;
    logic                flush_gap;
    logic [PtrW-1:0]     wr_idx;
    trace_rec_t          rec_in;

    assign full      = (count_q == CntW'(Depth));
    assign not_empty = (count_q != '0);

    // Flush wins over pop; a push lands at entry 0 during a flush, and a
    // pop in a full cycle frees the slot that this cycle's push takes.
    assign pop       = not_empty & trace_ready_i & ~flush_i;
    assign store     = rvfi_valid & (flush_i | ~full | pop);
    assign drop      = rvfi_valid & ~flush_i & full & ~pop;
    assign flush_gap = flush_i & not_empty;
    assign wr_idx    = flush_i ? '0 : wr_ptr_q;

    // Assemble the incoming record, tagging it if anything was lost before it.
    always_comb begin
        rec_in           = '0;
        rec_in.order     = rvfi_order[31:0];
        rec_in.pc        = rvfi_pc_rdata;
        rec_in.insn      = rvfi_insn;
        rec_in.rd_addr   = rvfi_rd_addr;
        rec_in.rd_wdata  = rvfi_rd_wdata;
        rec_in.mem_addr  = rvfi_mem_addr;
        rec_in.mem_rmask = rvfi_mem_rmask;
        rec_in.mem_wmask = rvfi_mem_wmask;
        rec_in.trap      = rvfi_trap;
        rec_in.intr      = rvfi_intr;
        rec_in.gap       = gap_q | flush_gap;
    end

    // Next pointer, count, gap and drop-counter values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gap_d    = gap_q;
        drop_d   = drop_q;

        if (flush_i) begin
            wr_ptr_d = store ? PtrW'(1) : '0;
            rd_ptr_d = '0;
            count_d  = store ? CntW'(1) : '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(store);
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
            count_d  = count_q + CntW'(store) - CntW'(pop);
        end

        if (store) begin
            gap_d = 1'b0;
        end else if (drop || flush_gap) begin
            gap_d = 1'b1;
        end

        if (clear_drop_i) begin
            drop_d = DropCntW'(drop);
        end else if (drop && !(&drop_q)) begin
            drop_d = drop_q + DropCntW'(1);
        end
    end

    // Control state register; storage itself is left unreset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            gap_q     <= 1'b0;
            drop_q    <= '0;
            rd_seen_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            drop_q    <= drop_d;
            if (store) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    // Record storage write.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_q[wr_idx] <= rec_in;
        end
    end

    // Head is a direct read of storage; forced to zero until the first
    // store after reset so the uninitialised array never reaches the port.
    assign trace_rec_o   = rd_seen_q ? mem_q[rd_ptr_q] : '0;
    assign trace_valid_o = not_empty;
    assign level_o       = count_q;
    assign drop_cnt_o    = drop_q;

endmodule
